// File: rtl/jogador_automatico_pkg.sv
// rtl/jogador_automatico_pkg.sv - shared state encodings, timing defaults and code helpers
package jogador_automatico_pkg;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESCUTA        = 3'd1,
    REGISTRA      = 3'd2,
    ESPERA_APAGAR = 3'd3,
    PRESSIONA     = 3'd4,
    SOLTA         = 3'd5,
    PROXIMA       = 3'd6,
    FIM           = 3'd7
  } estado_t;

  localparam int T_PRESS_PADRAO = 500;
  localparam int T_GAP_PADRAO   = 500;
  localparam int T_QUIET_PADRAO = 1500;
  localparam int TW             = 16;

  function automatic logic um_quente(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [3:0] rotaciona(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/jogador_automatico_temporizador.sv
// rtl/jogador_automatico_temporizador.sv - loadable down-counter with terminal flag
module temporizador #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic         conta,
  input  logic [W-1:0] valor,
  output logic         fim
);

  localparam logic [W-1:0] UM = 1;

  logic [W-1:0] cnt;

  // Saturates at zero so fim holds until the next load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (carrega) begin
      cnt <= valor;
    end else if (conta && (cnt != '0)) begin
      cnt <= cnt - UM;
    end
  end

  assign fim = (cnt == '0);

endmodule

// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - captures the game's LED sequence and replays it on the buttons
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int T_PRESS = T_PRESS_PADRAO,
  parameter int T_GAP   = T_GAP_PADRAO,
  parameter int T_QUIET = T_QUIET_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       injetar_erro,
  input  logic [3:0] erro_idx,
  input  logic       omitir,
  output logic [3:0] botoes,
  output logic       jogando,
  output logic [4:0] capturadas,
  output logic       invalido,
  output logic       overflow,
  output logic [3:0] db_estado
);

  localparam logic [TW-1:0] V_PRESS = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] V_GAP   = TW'(T_GAP - 1);
  localparam logic [TW-1:0] V_QUIET = TW'(T_QUIET - 1);

  estado_t       estado;
  logic [3:0]    codigo;
  logic [3:0]    idx;
  logic [3:0]    jogada;
  logic          erro_armado;
  logic [3:0]    mem [16];

  logic          sil_carrega, sil_fim;
  logic          tmp_carrega, tmp_fim;
  logic [TW-1:0] tmp_valor;

  // Silence timer restarts on any lit cycle; the press timer is preloaded outside replay.
  always_comb begin
    sil_carrega = (estado != ESCUTA) || (leds != 4'b0000);
    tmp_carrega = ((estado != PRESSIONA) && (estado != SOLTA)) ||
                  ((estado == PRESSIONA) && tmp_fim);
    tmp_valor   = (estado == PRESSIONA) ? V_GAP : V_PRESS;
    jogada      = mem[idx];
    if (erro_armado && (idx == erro_idx)) begin
      jogada = rotaciona(mem[idx]);
    end
  end

  temporizador #(.W(TW)) u_silencio (
    .clock   (clock),
    .reset   (reset),
    .carrega (sil_carrega),
    .conta   (1'b1),
    .valor   (V_QUIET),
    .fim     (sil_fim)
  );

  temporizador #(.W(TW)) u_pressao (
    .clock   (clock),
    .reset   (reset),
    .carrega (tmp_carrega),
    .conta   (1'b1),
    .valor   (tmp_valor),
    .fim     (tmp_fim)
  );

  always_ff @(posedge clock) begin
    if (reset && habilita && (estado == REGISTRA) && um_quente(codigo) &&
        (capturadas < 5'd16)) begin
      mem[capturadas[3:0]] <= codigo;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      botoes      <= 4'b0000;
      jogando     <= 1'b0;
      capturadas  <= 5'd0;
      idx         <= 4'd0;
      invalido    <= 1'b0;
      overflow    <= 1'b0;
      codigo      <= 4'b0000;
      erro_armado <= 1'b0;
    end else if (!habilita) begin
      estado  <= OCIOSO;
      botoes  <= 4'b0000;
      jogando <= 1'b0;
    end else begin
      botoes <= (estado == PRESSIONA) ? jogada : 4'b0000;
      case (estado)
        OCIOSO: estado <= ESCUTA;
        ESCUTA: begin
          // The code is latched here so a one-cycle flash is still classified.
          if (leds != 4'b0000) begin
            codigo <= leds;
            estado <= REGISTRA;
          end else if (sil_fim && (capturadas != 5'd0)) begin
            if (omitir) begin
              estado <= FIM;
            end else begin
              estado      <= PRESSIONA;
              jogando     <= 1'b1;
              idx         <= 4'd0;
              erro_armado <= injetar_erro;
            end
          end
        end
        REGISTRA: begin
          if (!um_quente(codigo)) begin
            invalido <= 1'b1;
          end else if (capturadas == 5'd16) begin
            overflow <= 1'b1;
          end else begin
            capturadas <= capturadas + 5'd1;
          end
          estado <= ESPERA_APAGAR;
        end
        ESPERA_APAGAR: begin
          if (leds == 4'b0000) begin
            estado <= ESCUTA;
          end
        end
        PRESSIONA: begin
          if (tmp_fim) begin
            estado <= SOLTA;
          end
        end
        SOLTA: begin
          if (tmp_fim) begin
            estado <= PROXIMA;
          end
        end
        PROXIMA: begin
          if (({1'b0, idx} + 5'd1) < capturadas) begin
            idx    <= idx + 4'd1;
            estado <= PRESSIONA;
          end else begin
            jogando <= 1'b0;
            estado  <= FIM;
          end
        end
        FIM: begin
          capturadas <= 5'd0;
          idx        <= 4'd0;
          estado     <= ESCUTA;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - scoreboard bench for the automatic player
module tb_jogador_automatico;

  localparam int TP = 5;
  localparam int TG = 3;
  localparam int TQ = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic       injetar_erro = 1'b0;
  logic [3:0] erro_idx = 4'd0;
  logic       omitir = 1'b0;
  logic [3:0] botoes;
  logic       jogando;
  logic [4:0] capturadas;
  logic       invalido;
  logic       overflow;
  logic [3:0] db_estado;

  jogador_automatico #(.T_PRESS(TP), .T_GAP(TG), .T_QUIET(TQ)) dut (
    .clock        (clock),
    .reset        (reset),
    .habilita     (habilita),
    .leds         (leds),
    .injetar_erro (injetar_erro),
    .erro_idx     (erro_idx),
    .omitir       (omitir),
    .botoes       (botoes),
    .jogando      (jogando),
    .capturadas   (capturadas),
    .invalido     (invalido),
    .overflow     (overflow),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] code;
    bit         first;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_codes[$];
  bit         exp_inv, exp_ovf;
  bit         monitor_en = 1'b0;
  bit         jog_seen;
  int         checks = 0;
  int         errors = 0;

  int         mon_run, mon_gap;
  bit         mon_in_press;
  logic [3:0] mon_cur;
  exp_t       mon_e;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [3:0] c);
    int n = 0;
    for (int i = 0; i < 4; i++) if (c[i]) n++;
    return n == 1;
  endfunction

  function automatic logic [3:0] corrupt(input logic [3:0] c);
    return (c == 4'b1000) ? 4'b0001 : (c << 1);
  endfunction

  function automatic logic [3:0] rand_code();
    logic [3:0] one = 4'b0001;
    return one << $urandom_range(0, 3);
  endfunction

  // Reference model: each lit period is one capture attempt.
  task automatic show(input logic [3:0] c, input int lit, input int dark);
    int l = (lit == 0) ? $urandom_range(1, 4) : lit;
    int d = (dark == 0) ? $urandom_range(2, 4) : dark;
    leds = c;
    repeat (l) tick();
    leds = 4'b0000;
    repeat (d) tick();
    if (!is_onehot(c)) exp_inv = 1'b1;
    else if (m_codes.size() == 16) exp_ovf = 1'b1;
    else m_codes.push_back(c);
  endtask

  task automatic check_display();
    @(negedge clock);
    check("capturadas", capturadas, m_codes.size());
    check("invalido", invalido, exp_inv);
    check("overflow", overflow, exp_ovf);
  endtask

  task automatic arm_replay(input bit inj, input int eidx);
    exp_t e;
    for (int i = 0; i < m_codes.size(); i++) begin
      e.code  = (inj && (i == eidx)) ? corrupt(m_codes[i]) : m_codes[i];
      e.first = (i == 0);
      sb.push_back(e);
    end
    m_codes.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || jogando || db_estado != 4'd1 || capturadas != 5'd0) &&
           n < budget) begin
      tick();
      n++;
    end
    check("replay_within_budget", (n < budget) ? 1 : 0, 1);
    sb.delete();
  endtask

  task automatic run_round(input logic [3:0] codes[$], input int lit, input int dark,
                           input bit inj, input int eidx);
    injetar_erro = inj;
    erro_idx     = eidx[3:0];
    omitir       = 1'b0;
    foreach (codes[i]) show(codes[i], lit, dark);
    check_display();
    arm_replay(inj, eidx);
    wait_done(3000);
    @(negedge clock);
    check("capturadas_after_fim", capturadas, 0);
    check("botoes_after_replay", botoes, 0);
    injetar_erro = 1'b0;
  endtask

  // Monitor: times every press and pops its expectation when it is released.
  initial begin
    mon_in_press = 1'b0;
    mon_gap = 0;
    mon_run = 0;
    mon_cur = 4'b0000;
    forever begin
      @(negedge clock);
      if (jogando) jog_seen = 1'b1;
      if (!monitor_en || !reset) begin
        mon_in_press = 1'b0;
        mon_gap = 0;
      end else if (botoes != 4'b0000) begin
        check("jogando_during_press", jogando, 1);
        if (!mon_in_press) begin
          mon_in_press = 1'b1;
          mon_cur = botoes;
          mon_run = 1;
          check("press_onehot", is_onehot(botoes), 1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_press: got %b expected none", botoes);
          end else if (!sb[0].first) begin
            checks++;
            if (mon_gap < TG || mon_gap > TG + 1) begin
              errors++;
              $display("FAIL gap_len: got %0d expected %0d..%0d", mon_gap, TG, TG + 1);
            end
          end
        end else if (botoes != mon_cur) begin
          checks++;
          errors++;
          $display("FAIL press_changed: got %b expected %b", botoes, mon_cur);
        end else begin
          mon_run++;
        end
      end else if (mon_in_press) begin
        mon_in_press = 1'b0;
        mon_gap = 1;
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("press_code", mon_cur, mon_e.code);
          check("press_len", mon_run, TP);
        end
      end else begin
        mon_gap++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] q[$];
    int n;

    repeat (3) tick();
    @(negedge clock);
    check("reset_botoes", botoes, 0);
    check("reset_jogando", jogando, 0);
    check("reset_capturadas", capturadas, 0);
    check("reset_invalido", invalido, 0);
    check("reset_overflow", overflow, 0);
    check("reset_db_estado", db_estado, 0);

    reset = 1'b1;
    habilita = 1'b1;
    monitor_en = 1'b1;
    tick();
    tick();
    @(negedge clock);
    check("enable_to_escuta", db_estado, 1);

    q = {4'b0001, 4'b0010, 4'b0100};
    run_round(q, 5, 3, 1'b0, 0);

    q = {4'b0001, 4'b1000};
    run_round(q, 0, 0, 1'b1, 1);

    show(4'b0011, 1, 3);
    check_display();

    q.delete();
    for (int i = 0; i < 17; i++) q.push_back(rand_code());
    run_round(q, 0, 0, 1'b0, 0);

    omitir = 1'b1;
    jog_seen = 1'b0;
    show(rand_code(), 0, 0);
    show(rand_code(), 0, 0);
    check_display();
    m_codes.delete();
    repeat (TQ + 8) tick();
    @(negedge clock);
    check("omit_jogando_never", jog_seen, 0);
    check("omit_botoes", botoes, 0);
    check("omit_capturadas", capturadas, 0);
    check("omit_back_to_escuta", db_estado, 1);
    omitir = 1'b0;

    monitor_en = 1'b0;
    show(4'b0010, 0, 0);
    show(4'b0100, 0, 0);
    n = 0;
    while (botoes == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    check("midreset_press_started", (n < 200) ? 1 : 0, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("midreset_botoes", botoes, 0);
    check("midreset_db_estado", db_estado, 0);
    check("midreset_capturadas", capturadas, 0);
    check("midreset_jogando", jogando, 0);
    check("midreset_invalido", invalido, 0);
    check("midreset_overflow", overflow, 0);
    m_codes.delete();
    exp_inv = 1'b0;
    exp_ovf = 1'b0;
    monitor_en = 1'b1;
    tick();

    for (int r = 0; r < 4; r++) begin
      int len = 6 + 3 * r;
      bit inj;
      int eidx;
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(rand_code());
      if (r == 0) begin
        inj = 1'b1;
        eidx = $urandom_range(len, 15);
      end else if (r == 1) begin
        inj = 1'b1;
        eidx = $urandom_range(0, len - 1);
      end else begin
        inj = $urandom_range(0, 1);
        eidx = $urandom_range(0, 15);
      end
      run_round(q, 0, 0, inj, eidx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
